// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin fetch/data arbiter for a single-port memory,
// with store lane steering, load extension, misalignment and timeout errors.
module mem_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic [WIDTH-1:0] if_addr,
    output logic             if_gnt,
    output logic [WIDTH-1:0] if_rdata,
    output logic             if_valid,
    output logic             if_err,
    input  logic             dm_req,
    input  logic             dm_we,
    input  logic [WIDTH-1:0] dm_addr,
    input  logic [WIDTH-1:0] dm_wdata,
    input  logic [2:0]       dm_op,
    output logic             dm_gnt,
    output logic [WIDTH-1:0] dm_rdata,
    output logic             dm_valid,
    output logic             dm_err,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_be,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready
);
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, ERR} state_t;
    state_t state, state_n;
    logic sel_dm, last_dm;
    logic [2:0] op_q;
    logic [1:0] lane_q;
    logic [7:0] cnt;
    logic any_req, pick_dm, dm_store_op, dm_word, dm_half, dm_mis, mis, st, busy, tmo, resp, err;
    logic [WIDTH-1:0] addr_s, wd_n, fmt;
    logic [3:0] be_n;
    logic [7:0] byte_v;
    logic [15:0] half_v;
    assign any_req     = if_req | dm_req;
    assign pick_dm     = dm_req & (~if_req | ~last_dm);
    assign addr_s      = pick_dm ? dm_addr : if_addr;
    assign dm_store_op = ~dm_op[2] & (|dm_op[1:0]);
    assign dm_word     = (dm_op == 3'b000) | (dm_op == 3'b011);
    assign dm_half     = (dm_op == 3'b101) | (dm_op == 3'b111) | (dm_op == 3'b010);
    // an op code whose direction disagrees with dm_we is rejected like a misalignment
    assign dm_mis      = (dm_store_op != dm_we) | (dm_word & (|dm_addr[1:0])) | (dm_half & dm_addr[0]);
    assign mis         = pick_dm ? dm_mis : |if_addr[1:0];
    assign st          = pick_dm & dm_we;
    assign be_n        = !st ? 4'hf : dm_op == 3'b001 ? 4'b0001 << dm_addr[1:0] :
                         dm_op == 3'b010 ? 4'b0011 << {dm_addr[1], 1'b0} : 4'hf;
    assign wd_n        = !st ? '0 : dm_op == 3'b001 ? {4{dm_wdata[7:0]}} :
                         dm_op == 3'b010 ? {2{dm_wdata[15:0]}} : dm_wdata;
    assign busy        = (state == BUSY_IF) | (state == BUSY_DM);
    assign tmo         = cnt == 8'(TIMEOUT - 1);
    assign mem_req     = busy;
    assign resp        = (busy & (mem_ready | tmo)) | (state == ERR);
    assign err         = (state == ERR) | (busy & ~mem_ready);
    assign byte_v      = mem_rdata[8*lane_q +: 8];
    assign half_v      = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    // fetches carry op 000 so they pass the word through like LW; stores read back 0
    assign fmt         = op_q == 3'b000 ? mem_rdata :
                         op_q == 3'b100 ? {{24{byte_v[7]}}, byte_v} :
                         op_q == 3'b110 ? {24'b0, byte_v} :
                         op_q == 3'b101 ? {{16{half_v[15]}}, half_v} :
                         op_q == 3'b111 ? {16'b0, half_v} : '0;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:             if (any_req) state_n = mis ? ERR : pick_dm ? BUSY_DM : BUSY_IF;
            BUSY_IF, BUSY_DM: if (mem_ready | tmo) state_n = IDLE;
            default:          state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_dm    <= 1'b0;
            last_dm   <= 1'b1;
            op_q      <= '0;
            lane_q    <= '0;
            cnt       <= '0;
            if_gnt    <= 1'b0;
            dm_gnt    <= 1'b0;
            if_valid  <= 1'b0;
            dm_valid  <= 1'b0;
            if_err    <= 1'b0;
            dm_err    <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else begin
            if_gnt   <= state == IDLE && any_req && !pick_dm;
            dm_gnt   <= state == IDLE && any_req && pick_dm;
            if_valid <= resp & ~sel_dm;
            dm_valid <= resp & sel_dm;
            if_err   <= resp & err & ~sel_dm;
            dm_err   <= resp & err & sel_dm;
            if_rdata <= (resp & ~err & ~sel_dm) ? fmt : '0;
            dm_rdata <= (resp & ~err & sel_dm) ? fmt : '0;
            if (state == IDLE && any_req) begin
                sel_dm    <= pick_dm;
                last_dm   <= pick_dm;
                op_q      <= pick_dm ? dm_op : 3'b000;
                lane_q    <= addr_s[1:0];
                cnt       <= '0;
                mem_we    <= st;
                mem_addr  <= {addr_s[WIDTH-1:2], 2'b00};
                mem_wdata <= wd_n;
                mem_be    <= be_n;
            end else if (busy && !mem_ready) begin
                cnt <= cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors with a response scoreboard for mem_arbiter.
module tb_mem_arbiter;
    logic clk = 0, rst = 1;
    logic if_req = 0, dm_req = 0, dm_we = 0, mem_ready = 0;
    logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, mem_rdata = 0;
    logic [2:0] dm_op = 0;
    logic if_gnt, if_valid, if_err, dm_gnt, dm_valid, dm_err, mem_req, mem_we;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic [3:0] mem_be;
    int vecs = 0, errs = 0;
    typedef struct packed {logic dm; logic err; logic [31:0] rdata;} resp_t;
    resp_t sb[$];
    resp_t mon_e;

    mem_arbiter #(.WIDTH(32), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_err(if_err),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_op(dm_op),
        .dm_gnt(dm_gnt), .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_err(dm_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && (if_valid || dm_valid)) begin
            if (sb.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL unexpected_resp: got if_valid=%b dm_valid=%b expected none", if_valid, dm_valid);
            end else begin
                mon_e = sb.pop_front();
                chk("resp_excl", {31'b0, if_valid & dm_valid}, 32'd0);
                chk("resp_port", {31'b0, dm_valid}, {31'b0, mon_e.dm});
                chk("resp_err", {31'b0, dm_valid ? dm_err : if_err}, {31'b0, mon_e.err});
                chk("resp_rdata", dm_valid ? dm_rdata : if_rdata, mon_e.rdata);
            end
        end
    end

    task automatic txn(input string nm, input logic fi, input logic fd, input logic exp_dm,
                       input logic exp_err, input logic [31:0] exp_rd, input logic [3:0] exp_be,
                       input logic [31:0] exp_wd, input logic [31:0] word, input int delay);
        logic got;
        logic use_mem;
        logic [31:0] ea;
        use_mem = !exp_err || delay < 0;
        @(posedge clk);
        #1;
        if_req = fi;
        dm_req = fd;
        sb.push_back(resp_t'{exp_dm, exp_err, exp_rd});
        got = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (if_gnt || dm_gnt) begin
                got = 1;
                break;
            end
        end
        if_req = 0;
        dm_req = 0;
        if (!got) begin
            vecs++;
            errs++;
            $display("FAIL %s_gnt: got none within 10 cycles expected a grant", nm);
            sb.delete();
            return;
        end
        chk({nm, "_gnt_dm"}, {31'b0, dm_gnt}, {31'b0, exp_dm});
        chk({nm, "_gnt_excl"}, {31'b0, if_gnt & dm_gnt}, 32'd0);
        chk({nm, "_mem_req"}, {31'b0, mem_req}, {31'b0, use_mem});
        if (use_mem) begin
            ea = (exp_dm ? dm_addr : if_addr) & ~32'h3;
            chk({nm, "_addr"}, mem_addr, ea);
            chk({nm, "_be"}, {28'b0, mem_be}, {28'b0, exp_be});
            chk({nm, "_we"}, {31'b0, mem_we}, {31'b0, exp_dm & dm_we});
            if (exp_dm && dm_we) chk({nm, "_wdata"}, mem_wdata, exp_wd);
            if (delay < 0) begin
                repeat (14) @(negedge clk);
                chk({nm, "_req_held"}, {31'b0, mem_req}, 32'd1);
                @(negedge clk);
                chk({nm, "_req_dropped"}, {31'b0, mem_req}, 32'd0);
            end else begin
                repeat (delay) @(negedge clk);
                mem_rdata = word;
                mem_ready = 1;
                @(negedge clk);
                mem_ready = 0;
                if (delay == 0) chk({nm, "_valid_lat"}, {31'b0, exp_dm ? dm_valid : if_valid}, 32'd1);
            end
        end
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            vecs++;
            errs++;
            $display("FAIL %s_resp: got no response expected one", nm);
            sb.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 0;
        #1;
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_gnt", {30'b0, if_gnt, dm_gnt}, 32'd0);
        chk("rst_valid", {30'b0, if_valid, dm_valid}, 32'd0);
        chk("rst_be_addr", mem_addr | {28'b0, mem_be}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1;
    endtask

    initial begin
        logic got;
        #1 rst = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        if_addr = 32'h10;
        txn("fetch", 1, 0, 0, 0, 32'h00500093, 4'hf, 0, 32'h00500093, 0);
        do_reset();
        if_addr = 32'h20;
        dm_we = 0;
        dm_op = 3'b000;
        dm_addr = 32'h40;
        txn("rr1", 1, 1, 0, 0, 32'hCAFEF00D, 4'hf, 0, 32'hCAFEF00D, 0);
        txn("rr2", 1, 1, 1, 0, 32'hCAFEF00D, 4'hf, 0, 32'hCAFEF00D, 0);
        txn("rr3", 1, 1, 0, 0, 32'hCAFEF00D, 4'hf, 0, 32'hCAFEF00D, 0);
        dm_we = 1;
        dm_op = 3'b001; dm_addr = 32'h103; dm_wdata = 32'h000000AB;
        txn("sb", 0, 1, 1, 0, 0, 4'b1000, 32'hABABABAB, 32'h55555555, 1);
        dm_op = 3'b010; dm_addr = 32'h102; dm_wdata = 32'h00001234;
        txn("sh", 0, 1, 1, 0, 0, 4'b1100, 32'h12341234, 32'h55555555, 0);
        dm_op = 3'b011; dm_addr = 32'h104; dm_wdata = 32'hDEADBEEF;
        txn("sw", 0, 1, 1, 0, 0, 4'hf, 32'hDEADBEEF, 32'h55555555, 0);
        dm_we = 0;
        dm_op = 3'b100; dm_addr = 32'h202;
        txn("lb", 0, 1, 1, 0, 32'hFFFFFFF0, 4'hf, 0, 32'h12F03456, 0);
        dm_op = 3'b110;
        txn("lbu", 0, 1, 1, 0, 32'h000000F0, 4'hf, 0, 32'h12F03456, 2);
        dm_op = 3'b101;
        txn("lh_hi", 0, 1, 1, 0, 32'h000012F0, 4'hf, 0, 32'h12F03456, 0);
        dm_addr = 32'h200;
        txn("lh_lo", 0, 1, 1, 0, 32'hFFFF8001, 4'hf, 0, 32'h12F08001, 0);
        dm_op = 3'b111;
        txn("lhu", 0, 1, 1, 0, 32'h00008001, 4'hf, 0, 32'h12F08001, 1);
        dm_op = 3'b000; dm_addr = 32'h208;
        txn("lw", 0, 1, 1, 0, 32'h89ABCDEF, 4'hf, 0, 32'h89ABCDEF, 3);
        dm_addr = 32'h6;
        txn("lw_mis", 0, 1, 1, 1, 0, 4'hf, 0, 0, 0);
        if_addr = 32'h2;
        txn("if_mis", 1, 0, 0, 1, 0, 4'hf, 0, 0, 0);
        dm_we = 1; dm_op = 3'b010; dm_addr = 32'h101;
        txn("sh_mis", 0, 1, 1, 1, 0, 4'hf, 0, 0, 0);
        dm_we = 0; dm_op = 3'b001; dm_addr = 32'h100;
        txn("bad_op", 0, 1, 1, 1, 0, 4'hf, 0, 0, 0);
        dm_op = 3'b000; dm_addr = 32'h300;
        txn("timeout", 0, 1, 1, 1, 0, 4'hf, 0, 0, -1);
        dm_addr = 32'h400;
        @(posedge clk);
        #1 dm_req = 1;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = dm_gnt;
        end
        dm_req = 0;
        chk("rst_mid_gnt", {31'b0, got}, 32'd1);
        repeat (3) @(negedge clk);
        rst = 0;
        #1;
        chk("rst_mid_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mid_out", {29'b0, dm_gnt, dm_valid, dm_err}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1;
        repeat (20) @(negedge clk);
        if_addr = 32'h44;
        txn("post_rst", 1, 0, 0, 0, 32'h00000013, 4'hf, 0, 32'h00000013, 0);
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
